vram_fill_arbiter: RTL and testbench

Owns the write-side VRAM port of the tile display controller and shares it between CPU bus accesses and a hardware fill engine. The fill engine writes a constant byte pattern over a contiguous, wrapping range of VRAM bytes, for clear-screen and solid-block operations, without CPU involvement. Sits between the CPU memory-mapped bus decoder and the VGA controller's `vram_addr/vram_wdata/vram_wenable/vram_rdata` port. Runs entirely in the `wclk` domain.

---
 rtl/vram_fill_arbiter.sv | 149 ++++++++++++++
 tb/tb_vram_fill_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_fill_arbiter.sv
// Shares the VRAM write port between CPU accesses and a constant-pattern fill engine.
// Define VRAM_FILL_ARB_FAIR_EN to force a fill slot after FAIR_N consecutive CPU grants.
module vram_fill_arbiter #(
    parameter int VRAM_SIZE = 126,
    parameter int ADDR_W    = $clog2(VRAM_SIZE),
    parameter int FAIR_N    = 4
) (
    input  logic              wclk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ready,
    output logic [7:0]        cpu_rdata,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_len,
    input  logic [7:0]        fill_pattern,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    output logic              vram_wenable,
    input  logic [7:0]        vram_rdata
);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    localparam logic [ADDR_W:0]   SIZE_L = (ADDR_W+1)'(VRAM_SIZE);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(VRAM_SIZE - 1);
    localparam logic [ADDR_W:0]   ONE_L  = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [7:0]        pattern_q, pattern_d;
    logic              done_q, done_d;
    logic              in_fill;
    logic              fill_slot;
    logic              cpu_grant;

    assign in_fill = (state_q == FILL);

`ifdef VRAM_FILL_ARB_FAIR_EN
    localparam int SW = $clog2(FAIR_N + 1);
    localparam logic [SW-1:0] FAIR_MAX = SW'(FAIR_N);

    logic [SW-1:0] streak_q, streak_d;

    assign fill_slot = in_fill & (~cpu_req | (streak_q == FAIR_MAX));

    always_comb begin
        streak_d = '0;
        if (in_fill && !fill_slot) begin
            streak_d = cpu_grant ? streak_q + 1'b1 : streak_q;
        end
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign fill_slot = in_fill & ~cpu_req;
`endif

    assign cpu_grant = cpu_req & ~fill_slot;
    assign cpu_rdata = vram_rdata;
    assign fill_busy = in_fill;
    assign fill_done = done_q;

    always_comb begin
        vram_addr    = cpu_addr;
        vram_wdata   = cpu_wdata;
        vram_wenable = 1'b0;
        cpu_ready    = 1'b0;
        unique case (1'b1)
            fill_slot: begin
                vram_addr    = cur_addr_q;
                vram_wdata   = pattern_q;
                vram_wenable = 1'b1;
            end
            cpu_grant: begin
                vram_wenable = cpu_we;
                cpu_ready    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        pattern_d   = pattern_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fill_start) begin
                    cur_addr_d  = fill_base;
                    pattern_d   = fill_pattern;
                    // Lengths past the VRAM size would only rewrite the same bytes
                    remaining_d = (fill_len > SIZE_L) ? SIZE_L : fill_len;
                    if (fill_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (fill_slot) begin
                    remaining_d = remaining_q - ONE_L;
                    cur_addr_d  = (cur_addr_q == LAST_A) ? '0
                                                         : cur_addr_q + 1'b1;
                    if (remaining_q == ONE_L) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            pattern_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            pattern_q   <= pattern_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_vram_fill_arbiter.sv
// Directed bench for vram_fill_arbiter with a behavioural VRAM array.
// Expected contention pattern follows VRAM_FILL_ARB_FAIR_EN.
module tb_vram_fill_arbiter;

    localparam int VS = 126;
    localparam int AW = 7;

    logic          wclk;
    logic          rst_n;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_ready;
    logic [7:0]    cpu_rdata;
    logic          fill_start;
    logic [AW-1:0] fill_base;
    logic [AW:0]   fill_len;
    logic [7:0]    fill_pattern;
    logic          fill_busy;
    logic          fill_done;
    logic [AW-1:0] vram_addr;
    logic [7:0]    vram_wdata;
    logic          vram_wenable;
    logic [7:0]    vram_rdata;

    logic [7:0] mem [0:VS-1];
    int total;
    int bad;

    vram_fill_arbiter #(
        .VRAM_SIZE(VS),
        .ADDR_W   (AW),
        .FAIR_N   (4)
    ) dut (
        .wclk        (wclk),
        .rst_n       (rst_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ready   (cpu_ready),
        .cpu_rdata   (cpu_rdata),
        .fill_start  (fill_start),
        .fill_base   (fill_base),
        .fill_len    (fill_len),
        .fill_pattern(fill_pattern),
        .fill_busy   (fill_busy),
        .fill_done   (fill_done),
        .vram_addr   (vram_addr),
        .vram_wdata  (vram_wdata),
        .vram_wenable(vram_wenable),
        .vram_rdata  (vram_rdata)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    assign vram_rdata = (int'(vram_addr) < VS) ? mem[vram_addr] : 8'h00;

    always @(posedge wclk) begin
        if (vram_wenable && int'(vram_addr) < VS) mem[vram_addr] <= vram_wdata;
    end

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_pattern = '0;
        #2;
        total++;
        if ({fill_busy, fill_done, cpu_ready, vram_wenable} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0000",
                     {fill_busy, fill_done, cpu_ready, vram_wenable});
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if ({fill_busy, fill_done, cpu_ready, vram_wenable} !== 4'b0000) begin
            bad++;
            $display("FAIL idle_outputs got=%b want=0000",
                     {fill_busy, fill_done, cpu_ready, vram_wenable});
        end
    endtask

    task automatic test_uncontended();
        int bases [3] = '{10, 124, 5};
        int lens  [3] = '{4, 4, 200};
        logic [7:0] pats [3] = '{8'hA5, 8'h3C, 8'h5A};
        for (int t = 0; t < 3; t++) begin
            int n = (lens[t] > VS) ? VS : lens[t];
            tick();
            fill_base = AW'(bases[t]);
            fill_len = (AW+1)'(lens[t]);
            fill_pattern = pats[t];
            fill_start = 1'b1;
            #1;
            total++;
            if (vram_wenable !== 1'b0 || fill_busy !== 1'b0) begin
                bad++;
                $display("FAIL fill%0d_start_cycle we=%b busy=%b want 0 0",
                         t, vram_wenable, fill_busy);
            end
            for (int i = 0; i < n; i++) begin
                logic [AW-1:0] ea;
                ea = AW'((bases[t] + i) % VS);
                tick();
                fill_start = 1'b0;
                #1;
                total++;
                if ({fill_busy, vram_wenable, vram_addr, vram_wdata} !==
                    {1'b1, 1'b1, ea, pats[t]}) begin
                    bad++;
                    $display("FAIL fill%0d_write%0d busy=%b we=%b a=%0d d=%h want 1 1 %0d %h",
                             t, i, fill_busy, vram_wenable, vram_addr, vram_wdata,
                             ea, pats[t]);
                end
            end
            tick();
            #1;
            total++;
            if ({fill_done, fill_busy, vram_wenable} !== 3'b100) begin
                bad++;
                $display("FAIL fill%0d_done got done/busy/we=%b want 100",
                         t, {fill_done, fill_busy, vram_wenable});
            end
            tick();
            #1;
            total++;
            if (fill_done !== 1'b0) begin
                bad++;
                $display("FAIL fill%0d_done_width got=%b want 0", t, fill_done);
            end
        end
    endtask

    task automatic test_zero_len();
        tick();
        fill_base = 7'd40; fill_len = '0; fill_pattern = 8'hFF; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        #1;
        total++;
        if ({fill_done, fill_busy, vram_wenable} !== 3'b100) begin
            bad++;
            $display("FAIL zero_len_done got done/busy/we=%b want 100",
                     {fill_done, fill_busy, vram_wenable});
        end
        tick();
        #1;
        total++;
        if ({fill_done, fill_busy, vram_wenable} !== 3'b000) begin
            bad++;
            $display("FAIL zero_len_after got done/busy/we=%b want 000",
                     {fill_done, fill_busy, vram_wenable});
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            tick();
            cpu_req = 1'b1; cpu_we = 1'b1;
            cpu_addr = AW'(30 + i); cpu_wdata = 8'(8'h40 + i);
            #1;
            total++;
            if ({cpu_ready, vram_wenable, vram_addr, vram_wdata} !==
                {1'b1, 1'b1, AW'(30 + i), 8'(8'h40 + i)}) begin
                bad++;
                $display("FAIL b2b_write%0d rdy=%b we=%b a=%0d d=%h",
                         i, cpu_ready, vram_wenable, vram_addr, vram_wdata);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            cpu_we = 1'b0; cpu_addr = AW'(30 + i);
            #1;
            total++;
            if ({cpu_ready, vram_wenable, cpu_rdata} !== {2'b10, 8'(8'h40 + i)}) begin
                bad++;
                $display("FAIL b2b_read%0d rdy=%b we=%b rd=%h want 1 0 %h",
                         i, cpu_ready, vram_wenable, cpu_rdata, 8'(8'h40 + i));
            end
        end
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic test_contention();
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'd50; cpu_wdata = 8'h11;
        fill_base = 7'd20; fill_len = 8'd3; fill_pattern = 8'h77; fill_start = 1'b1;
        #1;
        total++;
        if ({cpu_ready, vram_wenable, vram_addr} !== {2'b11, 7'd50}) begin
            bad++;
            $display("FAIL cont_start_grant rdy=%b we=%b a=%0d want 1 1 50",
                     cpu_ready, vram_wenable, vram_addr);
        end
`ifdef VRAM_FILL_ARB_FAIR_EN
        for (int k = 0; k < 15; k++) begin
            logic f;
            logic [AW-1:0] ea;
            logic [7:0] ed;
            f = (k % 5 == 4);
            ea = f ? AW'(20 + k / 5) : 7'd50;
            ed = f ? 8'h77 : 8'h11;
            tick();
            fill_start = 1'b0;
            #1;
            total++;
            if ({fill_busy, vram_wenable, cpu_ready, vram_addr, vram_wdata} !==
                {2'b11, ~f, ea, ed}) begin
                bad++;
                $display("FAIL cont_fair%0d busy=%b we=%b rdy=%b a=%0d d=%h want 1 1 %b %0d %h",
                         k, fill_busy, vram_wenable, cpu_ready, vram_addr,
                         vram_wdata, ~f, ea, ed);
            end
        end
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            fill_start = 1'b0;
            #1;
            total++;
            if ({fill_busy, vram_wenable, cpu_ready, vram_addr, vram_wdata} !==
                {3'b111, 7'd50, 8'h11}) begin
                bad++;
                $display("FAIL cont_starve%0d busy=%b we=%b rdy=%b a=%0d d=%h",
                         k, fill_busy, vram_wenable, cpu_ready, vram_addr, vram_wdata);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            cpu_req = 1'b0;
            #1;
            total++;
            if ({vram_wenable, cpu_ready, vram_addr, vram_wdata} !==
                {2'b10, AW'(20 + k), 8'h77}) begin
                bad++;
                $display("FAIL cont_release%0d we=%b rdy=%b a=%0d d=%h want 1 0 %0d 77",
                         k, vram_wenable, cpu_ready, vram_addr, vram_wdata, 20 + k);
            end
        end
`endif
        tick();
        cpu_req = 1'b0;
        #1;
        total++;
        if ({fill_done, fill_busy, vram_wenable} !== 3'b100) begin
            bad++;
            $display("FAIL cont_done got done/busy/we=%b want 100",
                     {fill_done, fill_busy, vram_wenable});
        end
    endtask

    task automatic test_read_back();
        tick();
        fill_base = 7'd5; fill_len = 8'd4; fill_pattern = 8'hC3; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        repeat (5) tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'd7;
        #1;
        total++;
        if ({cpu_ready, vram_wenable, cpu_rdata} !== {2'b10, 8'hC3}) begin
            bad++;
            $display("FAIL read_addr7 rdy=%b we=%b rd=%h want 1 0 c3",
                     cpu_ready, vram_wenable, cpu_rdata);
        end
        tick();
        cpu_addr = 7'd9;
        #1;
        total++;
        if ({cpu_ready, cpu_rdata} !== {1'b1, 8'h5A}) begin
            bad++;
            $display("FAIL read_addr9 rdy=%b rd=%h want 1 5a", cpu_ready, cpu_rdata);
        end
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic test_restart_ignored();
        tick();
        fill_base = 7'd0; fill_len = 8'd6; fill_pattern = 8'h33; fill_start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            fill_start = (k == 1);
            if (k == 1) begin
                fill_base = 7'd100; fill_len = 8'd10; fill_pattern = 8'hEE;
            end
            #1;
            total++;
            if ({fill_busy, vram_wenable, vram_addr, vram_wdata} !==
                {2'b11, AW'(k), 8'h33}) begin
                bad++;
                $display("FAIL restart_write%0d busy=%b we=%b a=%0d d=%h want 1 1 %0d 33",
                         k, fill_busy, vram_wenable, vram_addr, vram_wdata, k);
            end
        end
        tick();
        #1;
        total++;
        if ({fill_done, fill_busy, vram_wenable} !== 3'b100) begin
            bad++;
            $display("FAIL restart_done got done/busy/we=%b want 100",
                     {fill_done, fill_busy, vram_wenable});
        end
        repeat (2) tick();
        total++;
        if ({fill_busy, vram_wenable} !== 2'b00) begin
            bad++;
            $display("FAIL restart_quiet got busy/we=%b want 00",
                     {fill_busy, vram_wenable});
        end
    endtask

    task automatic test_reset_mid_fill();
        tick();
        fill_base = 7'd60; fill_len = 8'd20; fill_pattern = 8'h99; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        repeat (15) tick();
        total++;
        if ({fill_busy, vram_wenable, vram_addr} !== {2'b11, 7'd75}) begin
            bad++;
            $display("FAIL midfill_pre busy=%b we=%b a=%0d want 1 1 75",
                     fill_busy, vram_wenable, vram_addr);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({fill_busy, vram_wenable} !== 2'b00) begin
            bad++;
            $display("FAIL midfill_reset busy/we=%b want 00", {fill_busy, vram_wenable});
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if ({fill_busy, fill_done, vram_wenable} !== 3'b000) begin
                bad++;
                $display("FAIL midfill_after%0d busy/done/we=%b want 000",
                         k, {fill_busy, fill_done, vram_wenable});
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        for (int i = 0; i < VS; i++) mem[i] = 8'h00;
        test_reset();
        test_uncontended();
        test_zero_len();
        test_back_to_back();
        test_contention();
        test_read_back();
        test_restart_ignored();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
